// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32 M-extension multiply/divide unit.
//   Multiply uses a 32-step shift-add into a 64-bit accumulator.
//   Divide uses a 32-step restoring algorithm with a 33-bit partial remainder.
//   Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   accept a new operation (IDLE/DONE only)
//   muldiv_fn  in   funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b       in   rs1 / rs2 operands
//   flush      in   synchronous abort, wins over start
//   busy       out  high in ITER and FIX
//   done       out  one-cycle pulse, result valid
//   result     out  result, held from DONE until the next DONE
//
// state | meaning
// IDLE  | waiting for start
// ITER  | one multiply/divide step per edge, 32 steps
// FIX   | sign correction and result select
// DONE  | result valid for one cycle; may accept a new start
module muldiv_seq #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      muldiv_fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          fn_q, fn_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;    // product, or {0, dividend/quotient}
  logic [XLEN:0]       rem_q, rem_d;    // divide partial remainder
  logic [XLEN-1:0]     divs_q, divs_d;  // |b|: multiplicand or divisor
  logic [XLEN-1:0]     result_q, result_d;

  logic                signed_a, signed_b, sa_n, sb_n, accept;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum;
  logic [XLEN+1:0]     rem_sh, rem_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  assign signed_a = (muldiv_fn == 3'b001) || (muldiv_fn == 3'b010) ||
                    (muldiv_fn == 3'b100) || (muldiv_fn == 3'b110);
  assign signed_b = (muldiv_fn == 3'b001) || (muldiv_fn == 3'b100) ||
                    (muldiv_fn == 3'b110);
  assign sa_n  = signed_a & a[XLEN-1];
  assign sb_n  = signed_b & b[XLEN-1];
  assign mag_a = sa_n ? -a : a;
  assign mag_b = sb_n ? -b : b;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, divs_q};
  // Remainder is always below the divisor, so the shifted value fits in 33 bits
  // and bit 33 of the difference is a clean borrow flag.
  assign rem_sh   = {rem_q, acc_q[XLEN-1]};
  assign rem_diff = rem_sh - {2'b00, divs_q};

  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  assign accept = start && !flush && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    divs_d   = divs_q;
    result_d = result_q;

    case (state_q)
      ITER: begin
        if (fn_q[2]) begin
          if (!rem_diff[XLEN+1]) begin
            rem_d = rem_diff[XLEN:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[XLEN:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
          end
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[XLEN-1:1]};
          else          acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (&cnt_q) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        case (fn_q)
          3'b000:         result_d = prod_fix[XLEN-1:0];
          3'b100, 3'b101: result_d = quo_fix;
          3'b110, 3'b111: result_d = rem_fix;
          default:        result_d = prod_fix[2*XLEN-1:XLEN];
        endcase
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      fn_d   = muldiv_fn;
      sa_d   = sa_n;
      sb_d   = sb_n;
      divs_d = mag_b;
      acc_d  = {{XLEN{1'b0}}, mag_a};
      rem_d  = '0;
      cnt_d  = '0;
      if (muldiv_fn[2] && (b == '0)) begin
        state_d  = DONE;
        result_d = muldiv_fn[1] ? a : '1;
      end else if (muldiv_fn[2] && !muldiv_fn[0] && (a == MIN_NEG) && (b == '1)) begin
        state_d  = DONE;
        result_d = muldiv_fn[1] ? '0 : MIN_NEG;
      end else begin
        state_d = ITER;
      end
    end

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fn_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      divs_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      divs_q   <= divs_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ITER) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  muldiv_fn = 3'b000;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                         F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .muldiv_fn(muldiv_fn),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] fn, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    muldiv_fn = fn;
    a = av;
    b = bv;
    step();
    start = 1'b0;
  endtask

  // Latency counts edges after the accepting edge; busy counts sampled busy cycles.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat,
                           input int exp_busy, input int lat0, input int busy0);
    int lat, nb;
    lat = lat0;
    nb  = busy0;
    while (!done && lat < 100) begin
      if (busy) nb++;
      step();
      lat++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(nb), 32'(exp_busy));
    check({tag, " busy in done"}, 32'(busy), 32'd0);
    check({tag, " result"}, result, exp);
  endtask

  task automatic after_done(input string tag, input logic [31:0] exp);
    step();
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " result hold"}, result, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp, input bit special);
    issue(fn, av, bv);
    if (special) wait_done(tag, exp, 0, 0, 0, 0);
    else         wait_done(tag, exp, 33, 33, 0, 0);
    after_done(tag, exp);
  endtask

  initial begin
    int lat, nb;

    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_op("mul 7*-3", F_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op("mulhu max", F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mulhsu -1*2", F_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0);
    run_op("mulh -1*-1", F_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_op("mulh min*min", F_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("div -7/2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    run_op("rem -7/2", F_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
    run_op("divu 100/7", F_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu 100/7", F_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("div 7/-2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    run_op("rem 7/-2", F_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0);
    run_op("divu max/1", F_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0);
    run_op("divu min/max", F_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0);

    run_op("divu 5/0", F_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);
    run_op("remu 5/0", F_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
    run_op("div ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("rem ovf", F_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1);
    run_op("div -7/0", F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b1);
    run_op("rem -7/0", F_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b1);

    // start raised mid-ITER must not disturb the operation in flight
    issue(F_DIVU, 32'd100, 32'd7);
    lat = 0;
    nb  = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        start = 1'b1;
        muldiv_fn = F_MUL;
        a = 32'd3;
        b = 32'd3;
      end
      if (busy) nb++;
      step();
      lat++;
    end
    start = 1'b0;
    wait_done("start ignored", 32'd14, 33, 33, lat, nb);
    after_done("start ignored", 32'd14);

    // back-to-back: second start presented during the DONE cycle
    issue(F_MUL, 32'd7, 32'hFFFFFFFD);
    wait_done("b2b first", 32'hFFFFFFEB, 33, 33, 0, 0);
    issue(F_DIVU, 32'd1000, 32'd3);
    wait_done("b2b second", 32'd333, 33, 33, 0, 0);
    after_done("b2b second", 32'd333);

    // flush on edge 10 of a DIV
    issue(F_DIV, 32'd1000, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    check("flush result kept", result, 32'd333);
    step();
    check("flush idle done", 32'(done), 32'd0);
    run_op("div after flush", F_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0);

    // flush wins over start; DIVU by zero would otherwise reach DONE at once
    start = 1'b1;
    flush = 1'b1;
    muldiv_fn = F_DIVU;
    a = 32'd9;
    b = 32'd0;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("flush prio busy", 32'(busy), 32'd0);
    check("flush prio done", 32'(done), 32'd0);
    check("flush prio result", result, 32'hFFFFFFF2);

    // asynchronous reset mid-ITER
    issue(F_MUL, 32'd7, 32'd9);
    repeat (10) step();
    check("pre-reset busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post-reset done", 32'(done), 32'd0);
    run_op("mul after reset", F_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
